// File: rtl/unit_output_read.sv
// unit_output_read: drains one unit's output store in address order onto a valid/ready stream
module unit_output_read #(
  parameter int   DATA_WIDTH                = 32,
  parameter int   NUM_OUTPUT_WORDS_PER_UNIT = 16,
  parameter int   BITS_OUTPUT_ADDR_PER_UNIT = 4,
  parameter int   BITS_ROW_IDX              = 10,
  parameter int   DATA_PRECISION            = 16,
  parameter logic MODE_WORK                 = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst_b,
  input  logic                                 mode,
  input  logic                                 start,
  input  logic [BITS_OUTPUT_ADDR_PER_UNIT-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]                rd_data,
  output logic [BITS_OUTPUT_ADDR_PER_UNIT-1:0] rd_addr,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [BITS_ROW_IDX-1:0]              out_row_idx,
  output logic [DATA_PRECISION-1:0]            out_value,
  output logic                                 out_last,
  output logic                                 busy,
  output logic                                 done
);
  typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;
  localparam int unused_depth = NUM_OUTPUT_WORDS_PER_UNIT;
  state_t state, state_nxt;
  logic [BITS_OUTPUT_ADDR_PER_UNIT-1:0] count;
  logic work, go, empty_go, load, at_last, finish, abort;
  logic unused_bits;
  assign unused_bits = ^rd_data[DATA_WIDTH-BITS_ROW_IDX-DATA_PRECISION-1:0];
  assign busy = state != IDLE;
  // next state plus the per-cycle control decisions shared with the datapath
  always_comb begin
    work      = mode == MODE_WORK;
    go        = state == IDLE && start && !work;
    empty_go  = go && wr_addr == '0;
    abort     = state != IDLE && work;
    load      = state == READ && !work && (!out_valid || out_ready);
    at_last   = rd_addr == count - 1'b1;
    finish    = state == FLUSH && !work && out_valid && out_ready && out_last;
    state_nxt = state;
    if (abort)
      state_nxt = IDLE;
    else if (go)
      state_nxt = empty_go ? IDLE : READ;
    else if (load && at_last)
      state_nxt = FLUSH;
    else if (finish)
      state_nxt = IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end
  // count latch, read pointer, output beat register and done pulse
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      count       <= '0;
      rd_addr     <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_row_idx <= '0;
      out_value   <= '0;
      done        <= 1'b0;
    end else begin
      done <= abort || finish || empty_go;
      if (go) begin
        count   <= wr_addr;
        rd_addr <= '0;
      end else if (abort) begin
        rd_addr   <= '0;
        out_valid <= 1'b0;
      end else if (load) begin
        out_row_idx <= rd_data[DATA_WIDTH-1 -: BITS_ROW_IDX];
        out_value   <= rd_data[DATA_WIDTH-BITS_ROW_IDX-1 -: DATA_PRECISION];
        out_valid   <= 1'b1;
        out_last    <= at_last;
        rd_addr     <= at_last ? rd_addr : rd_addr + 1'b1;
      end else if (finish) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_unit_output_read.sv
// tb_unit_output_read: randomized and directed drains checked against a queue-based model
module tb_unit_output_read;
  logic        clk, rst_b, mode, start, out_ready;
  logic [3:0]  wr_addr, rd_addr;
  logic [31:0] rd_data;
  logic        out_valid, out_last, busy, done;
  logic [9:0]  out_row_idx;
  logic [15:0] out_value;
  logic [31:0] mem [16];
  int checks = 0, failures = 0;
  int rmode = 0, pidx = 0;
  int pat [6] = '{1, 0, 0, 1, 0, 1};
  int m_active = 0, m_age = 0, m_acc = 0, m_cnt = 0, m_rd = 0, m_done = 0, st_on = 0, max_rd = 0;
  logic [31:0] q [$];
  logic [9:0]  acc_rows [$];
  logic        acc_last [$];
  logic [9:0]  pr;
  logic [15:0] pv;
  logic        pl;
  assign rd_data = mem[rd_addr];
  unit_output_read dut (
    .clk(clk), .rst_b(rst_b), .mode(mode), .start(start), .wr_addr(wr_addr),
    .rd_data(rd_data), .rd_addr(rd_addr), .out_valid(out_valid), .out_ready(out_ready),
    .out_row_idx(out_row_idx), .out_value(out_value), .out_last(out_last),
    .busy(busy), .done(done)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  function automatic logic [31:0] mk(input int r, input int v);
    logic [31:0] x;
    x = $urandom;
    return {r[9:0], v[15:0], x[5:0]};
  endfunction
  // downstream ready: always, fixed 1,0,0,1,0,1 pattern, or random
  always @(posedge clk) begin
    #1;
    out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? pat[pidx][0] : 1'($urandom_range(0, 1));
    pidx = (pidx + 1) % 6;
  end
  // reference model: words queued at start, popped on each handshake; checked every cycle
  always @(negedge clk) begin
    int erd;
    logic [31:0] w;
    if (!rst_b) begin
      m_active = 0; m_age = 0; m_acc = 0; m_rd = 0; m_done = 0; st_on = 0;
      q.delete();
    end else begin
      erd = m_active ? ((m_acc + (m_age >= 1)) < m_cnt - 1 ? m_acc + (m_age >= 1) : m_cnt - 1) : m_rd;
      chk("out_valid", out_valid, m_active && m_age >= 1);
      chk("busy", busy, m_active);
      chk("done", done, m_done);
      chk("rd_addr", rd_addr, erd);
      if (st_on && out_valid) begin
        chk("hold_row", out_row_idx, pr);
        chk("hold_value", out_value, pv);
        chk("hold_last", out_last, pl);
      end
      if (m_active && rd_addr > max_rd) max_rd = rd_addr;
      m_done = 0;
      st_on = 0;
      if (m_active && mode == 1'b1) begin
        m_active = 0; m_done = 1; m_rd = 0;
        q.delete();
      end else if (m_active) begin
        if (out_valid && out_ready && q.size() > 0) begin
          w = q.pop_front();
          chk("beat_row", out_row_idx, w[31:22]);
          chk("beat_value", out_value, w[21:6]);
          chk("beat_last", out_last, q.size() == 0);
          acc_rows.push_back(out_row_idx);
          acc_last.push_back(out_last);
          m_acc++;
          if (q.size() == 0) begin
            m_active = 0; m_done = 1; m_rd = m_cnt - 1;
          end
        end else if (out_valid && !out_ready) begin
          st_on = 1; pr = out_row_idx; pv = out_value; pl = out_last;
        end
        m_age++;
      end else if (start && mode == 1'b0) begin
        m_rd = 0;
        q.delete();
        if (wr_addr == 0) m_done = 1;
        else begin
          m_active = 1; m_age = 0; m_acc = 0; m_cnt = wr_addr;
          for (int i = 0; i < m_cnt; i++) q.push_back(mem[i]);
        end
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start(input int n);
    wr_addr = 4'(n);
    start = 1;
    cyc();
    start = 0;
  endtask
  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy || m_active != 0) && n < 400) begin
      cyc();
      n++;
    end
    chk(nm, n >= 400, 0);
    cyc();
  endtask
  task automatic check_rows5(input string nm);
    int er [5] = '{3, 5, 7, 9, 11};
    chk({nm, "_count"}, acc_rows.size(), 5);
    for (int i = 0; i < 5 && i < acc_rows.size(); i++) begin
      chk({nm, "_row"}, acc_rows[i], er[i]);
      chk({nm, "_last"}, acc_last[i], i == 4);
    end
  endtask
  task automatic check_reset(input string nm);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_last"}, out_last, 0);
    chk({nm, "_row"}, out_row_idx, 0);
    chk({nm, "_value"}, out_value, 0);
    chk({nm, "_rd_addr"}, rd_addr, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    rst_b = 0; mode = 0; start = 0; wr_addr = 0; out_ready = 0;
    for (int i = 0; i < 16; i++) mem[i] = mk($urandom, $urandom);
    for (int i = 0; i < 5; i++) mem[i] = mk(3 + 2 * i, 10 + i);
    #23;
    check_reset("reset");
    cyc();
    rst_b = 1;
    cyc();
    pulse_start(0);
    chk("empty_done", done, 1);
    chk("empty_busy", busy, 0);
    cyc();
    chk("empty_done_clear", done, 0);
    chk("empty_valid", out_valid, 0);
    mode = 1;
    pulse_start(5);
    chk("work_start_busy", busy, 0);
    cyc();
    chk("work_start_done", done, 0);
    mode = 0;
    rmode = 0;
    cyc();
    acc_rows.delete(); acc_last.delete();
    pulse_start(5);
    n = 0;
    while (!done && n < 40) begin
      cyc();
      n++;
    end
    chk("full_done_latency", n, 6);
    cyc();
    chk("full_done_width", done, 0);
    check_rows5("full");
    rmode = 1;
    max_rd = 0;
    acc_rows.delete(); acc_last.delete();
    pulse_start(5);
    wait_idle("bp_bound");
    check_rows5("bp");
    chk("bp_max_rd", max_rd, 4);
    rmode = 0;
    cyc();
    pulse_start(5);
    cyc();
    cyc();
    chk("mid_reset_pre_valid", out_valid, 1);
    rst_b = 0;
    #1;
    check_reset("mid_reset");
    cyc();
    rst_b = 1;
    cyc();
    acc_rows.delete(); acc_last.delete();
    pulse_start(5);
    wait_idle("post_reset_bound");
    check_rows5("post_reset");
    for (int i = 0; i < 16; i++) mem[i] = mk($urandom, $urandom);
    rmode = 2;
    acc_rows.delete(); acc_last.delete();
    pulse_start(15);
    wait_idle("max_bound");
    chk("max_count", acc_rows.size(), 15);
    if (acc_rows.size() == 15) begin
      chk("max_last14", acc_last[14], 1);
      chk("max_last13", acc_last[13], 0);
    end
    rmode = 0;
    cyc();
    acc_rows.delete(); acc_last.delete();
    pulse_start(10);
    n = 0;
    while (acc_rows.size() < 1 && n < 20) begin
      cyc();
      n++;
    end
    pulse_start(3);
    n = 0;
    while (acc_rows.size() < 2 && n < 20) begin
      cyc();
      n++;
    end
    chk("abort_busy_before", busy, 1);
    mode = 1;
    cyc();
    chk("abort_valid", out_valid, 0);
    chk("abort_done", done, 1);
    chk("abort_rd_addr", rd_addr, 0);
    chk("abort_busy", busy, 0);
    mode = 0;
    cyc();
    chk("abort_done_clear", done, 0);
    chk("abort_accepts", acc_rows.size(), 2);
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 16; i++) mem[i] = mk($urandom, $urandom);
      rmode = 2;
      pulse_start($urandom_range(0, 15));
      n = 0;
      while ((busy || m_active != 0) && n < 300) begin
        wr_addr = 4'($urandom);
        start = $urandom_range(0, 7) == 0;
        mode = $urandom_range(0, 40) == 0;
        cyc();
        n++;
      end
      start = 0;
      mode = 0;
      chk("rand_bound", n >= 300, 0);
      cyc();
    end
    cyc();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
